// File: rtl/reg_bus_bridge_pkg.sv
// Shared types and constants for the register-bank command bridge.
package reg_bus_bridge_pkg;

    localparam int unsigned CMD_WR_BIT    = 7;
    localparam logic [7:0]  CMD_RSVD_MASK = 8'h70;
    localparam int unsigned ADDR_W        = 4;
    localparam int unsigned DATA_W        = 16;

    typedef enum logic [2:0] {
        StIdle,
        StWrHi,
        StWrLo,
        StWrIssue,
        StRdIssue,
        StRdWait,
        StTxHi,
        StTxLo
    } state_t;

endpackage

// File: rtl/reg_bus_bridge_gap_timer.sv
// Inter-byte gap timer for write frames. Loaded on every accepted byte, decremented on
// every idle cycle; o_last flags that the next idle cycle is the TIMEOUT-th one.
module rb_gap_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_tick,
    output logic o_last
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] r_cnt;

    // Down-counter: reload on a byte, count idle cycles down towards 1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CW'(TIMEOUT);
        end else if (i_tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // TIMEOUT of zero disables expiry entirely.
    assign o_last = (TIMEOUT != 0) && (r_cnt == CW'(1));

endmodule

// File: rtl/reg_bus_bridge.sv
// Byte-stream command front-end for the 16x16 register bank: decodes write/read
// commands, strobes the bank, and returns read data as two bytes MSB first.
module reg_bus_bridge
    import reg_bus_bridge_pkg::*;
#(
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_write_en,
    output logic              o_read_en,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_reg_wdata,
    input  logic [DATA_W-1:0] i_reg_rdata,
    output logic              o_busy,
    output logic              o_err
);

    state_t              r_state, w_state_d;
    logic [ADDR_W-1:0]   r_addr, w_addr_d;
    logic [DATA_W-1:0]   r_wdata, w_wdata_d;
    logic [DATA_W-1:0]   r_hold, w_hold_d;
    logic [2:0]          r_lat, w_lat_d;
    logic                r_err, w_err_d;
    // Holds rx_ready low while in reset and until the first edge after release.
    logic                r_rdy_en;
    logic                w_accept;
    logic                w_load;
    logic                w_tick;
    logic                w_last;

    rb_gap_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_gap_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_load),
        .i_tick  (w_tick),
        .o_last  (w_last)
    );

    assign w_accept = i_rx_valid && o_rx_ready;

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_hold   <= '0;
            r_lat    <= '0;
            r_err    <= 1'b0;
            r_rdy_en <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_addr   <= w_addr_d;
            r_wdata  <= w_wdata_d;
            r_hold   <= w_hold_d;
            r_lat    <= w_lat_d;
            r_err    <= w_err_d;
            r_rdy_en <= 1'b1;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        w_state_d = r_state;
        w_addr_d  = r_addr;
        w_wdata_d = r_wdata;
        w_hold_d  = r_hold;
        w_lat_d   = r_lat;
        w_err_d   = 1'b0;
        w_load    = 1'b0;
        w_tick    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if ((i_rx_data & CMD_RSVD_MASK) != 8'h00) begin
                        w_err_d = 1'b1;
                    end else begin
                        w_addr_d = i_rx_data[ADDR_W-1:0];
                        if (i_rx_data[CMD_WR_BIT]) begin
                            w_load    = 1'b1;
                            w_state_d = StWrHi;
                        end else begin
                            w_state_d = StRdIssue;
                        end
                    end
                end
            end
            StWrHi: begin
                if (w_accept) begin
                    w_wdata_d[15:8] = i_rx_data;
                    w_load          = 1'b1;
                    w_state_d       = StWrLo;
                end else begin
                    w_tick = 1'b1;
                    if (w_last) begin
                        w_err_d   = 1'b1;
                        w_state_d = StIdle;
                    end
                end
            end
            StWrLo: begin
                if (w_accept) begin
                    w_wdata_d[7:0] = i_rx_data;
                    w_state_d      = StWrIssue;
                end else begin
                    w_tick = 1'b1;
                    if (w_last) begin
                        w_err_d   = 1'b1;
                        w_state_d = StIdle;
                    end
                end
            end
            StWrIssue: begin
                w_state_d = StIdle;
            end
            StRdIssue: begin
                if (RD_LAT == 0) begin
                    w_hold_d  = i_reg_rdata;
                    w_state_d = StTxHi;
                end else begin
                    // Counter reaches zero in the cycle reg_rdata is due.
                    w_lat_d   = 3'(RD_LAT - 1);
                    w_state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (r_lat == 3'd0) begin
                    w_hold_d  = i_reg_rdata;
                    w_state_d = StTxHi;
                end else begin
                    w_lat_d = r_lat - 3'd1;
                end
            end
            StTxHi: begin
                if (i_tx_ready) begin
                    w_state_d = StTxLo;
                end
            end
            StTxLo: begin
                if (i_tx_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        o_rx_ready  = r_rdy_en &&
                      ((r_state == StIdle) || (r_state == StWrHi) || (r_state == StWrLo));
        o_busy      = (r_state != StIdle);
        o_write_en  = (r_state == StWrIssue);
        o_read_en   = (r_state == StRdIssue);
        o_tx_valid  = (r_state == StTxHi) || (r_state == StTxLo);
        o_tx_data   = 8'h00;
        if (r_state == StTxHi) begin
            o_tx_data = r_hold[15:8];
        end else if (r_state == StTxLo) begin
            o_tx_data = r_hold[7:0];
        end
        o_addr      = r_addr;
        o_reg_wdata = r_wdata;
        o_err       = r_err;
    end

endmodule
